// File: rtl/automatic_headlight_control_if.sv
// automatic_headlight_control_if: sensor inputs and lamp outputs of the headlight controller.
interface automatic_headlight_control_if;
  logic       light_sensor;
  logic       rain_sensor;
  logic       ignition;
  logic [7:0] speed_sensor;
  logic       headlights;
  logic [7:0] dim_level;
  modport master(output light_sensor, rain_sensor, ignition, speed_sensor, input headlights, dim_level);
  modport slave(input light_sensor, rain_sensor, ignition, speed_sensor, output headlights, dim_level);
endinterface

// File: rtl/automatic_headlight_control.sv
// automatic_headlight_control: debounced light/rain, speed hysteresis and ramped lamp brightness.
module automatic_headlight_control #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SPEED_HI        = 100,
  parameter int SPEED_LO        = 80,
  parameter int RAMP_STEP       = 16,
  parameter int LOW_BEAM        = 128,
  parameter int RAIN_BEAM       = 192,
  parameter int HIGH_BEAM       = 255
) (
  input logic clk,
  input logic rst_n,
  automatic_headlight_control_if.slave bus
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] STEP = 8'(RAMP_STEP);
  logic [1:0] ign_s, light_s, rain_s;
  logic light_db, rain_db, high;
  logic [CW-1:0] light_cnt, rain_cnt;
  logic ign;
  logic [7:0] target, up, dn, next_dim;
  assign ign = ign_s[1];
  always_comb begin
    target = !ign ? 8'd0 : rain_db ? 8'(RAIN_BEAM) : light_db ? 8'd0 : high ? 8'(HIGH_BEAM) : 8'(LOW_BEAM);
    up = target - bus.dim_level;
    dn = bus.dim_level - target;
    // steps are clamped to the remaining distance, so the level can never overshoot or wrap
    next_dim = !ign ? 8'd0 :
               bus.dim_level < target ? bus.dim_level + (up > STEP ? STEP : up) :
               bus.dim_level - (dn > STEP ? STEP : dn);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ign_s         <= 2'b00;
      light_s       <= 2'b11;
      rain_s        <= 2'b00;
      light_db      <= 1'b1;
      rain_db       <= 1'b0;
      light_cnt     <= '0;
      rain_cnt      <= '0;
      high          <= 1'b0;
      bus.dim_level <= 8'd0;
      bus.headlights <= 1'b0;
    end else begin
      ign_s         <= {ign_s[0], bus.ignition};
      light_s       <= {light_s[0], bus.light_sensor};
      rain_s        <= {rain_s[0], bus.rain_sensor};
      light_cnt     <= light_s[1] == light_db || light_cnt == LAST ? '0 : light_cnt + 1'b1;
      light_db      <= light_s[1] != light_db && light_cnt == LAST ? light_s[1] : light_db;
      rain_cnt      <= rain_s[1] == rain_db || rain_cnt == LAST ? '0 : rain_cnt + 1'b1;
      rain_db       <= rain_s[1] != rain_db && rain_cnt == LAST ? rain_s[1] : rain_db;
      high          <= !ign ? 1'b0 :
                       bus.speed_sensor >= 8'(SPEED_HI) ? 1'b1 :
                       bus.speed_sensor < 8'(SPEED_LO) ? 1'b0 : high;
      bus.dim_level  <= next_dim;
      bus.headlights <= ign && (target != 8'd0 || bus.dim_level != 8'd0);
    end
  end
endmodule

// File: tb/tb_automatic_headlight_control.sv
// tb_automatic_headlight_control: directed stimulus checked against a cycle model plus literal expectations.
module tb_automatic_headlight_control;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  automatic_headlight_control_if bus();
  automatic_headlight_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int m_i0 = 0, m_i1 = 0, m_l0 = 1, m_l1 = 1, m_r0 = 0, m_r1 = 0;
  int m_ldb = 1, m_rdb = 0, m_lrun = 0, m_rrun = 0, m_high = 0, m_dim = 0, m_hl = 0;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int target_of(input int ign, input int rain, input int light, input int hi);
    if (ign == 0) return 0;
    if (rain != 0) return 192;
    if (light != 0) return 0;
    return hi != 0 ? 255 : 128;
  endfunction
  task automatic model_reset();
    m_i0 = 0; m_i1 = 0; m_l0 = 1; m_l1 = 1; m_r0 = 0; m_r1 = 0;
    m_ldb = 1; m_rdb = 0; m_lrun = 0; m_rrun = 0; m_high = 0; m_dim = 0; m_hl = 0;
  endtask
  task automatic model_step();
    int tgt, delta, spd;
    spd = int'(bus.speed_sensor);
    tgt = target_of(m_i1, m_rdb, m_ldb, m_high);
    delta = tgt - m_dim;
    if (delta > 16) delta = 16;
    if (delta < -16) delta = -16;
    m_hl = (m_i1 != 0 && (tgt != 0 || m_dim != 0)) ? 1 : 0;
    m_dim = m_i1 == 0 ? 0 : m_dim + delta;
    m_high = m_i1 == 0 ? 0 : spd >= 100 ? 1 : spd < 80 ? 0 : m_high;
    // a change is accepted after D consecutive differing synchronised samples
    if (m_l1 != m_ldb) begin
      m_lrun++;
      if (m_lrun == D) begin m_ldb = m_l1; m_lrun = 0; end
    end else m_lrun = 0;
    if (m_r1 != m_rdb) begin
      m_rrun++;
      if (m_rrun == D) begin m_rdb = m_r1; m_rrun = 0; end
    end else m_rrun = 0;
    m_i1 = m_i0; m_i0 = int'(bus.ignition);
    m_l1 = m_l0; m_l0 = int'(bus.light_sensor);
    m_r1 = m_r0; m_r0 = int'(bus.rain_sensor);
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end
  initial forever begin
    @(negedge clk);
    chk("model_dim", int'(bus.dim_level), m_dim);
    chk("model_headlights", int'(bus.headlights), m_hl);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_out(input string name, input int dim, input int hl);
    chk({name, "_dim"}, int'(bus.dim_level), dim);
    chk({name, "_hl"}, int'(bus.headlights), hl);
  endtask
  task automatic set_in(input int ign, input int light, input int rain, input int spd);
    bus.ignition = ign[0];
    bus.light_sensor = light[0];
    bus.rain_sensor = rain[0];
    bus.speed_sensor = 8'(spd);
  endtask
  initial begin
    set_in(0, 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(50);
    expect_out("ign_off_idle", 0, 0);
    set_in(1, 1, 0, 30);
    cyc(20);
    expect_out("day_dry", 0, 0);
    set_in(1, 0, 0, 30);
    cyc(6);
    expect_out("dark_before_step", 0, 0);
    cyc(1);
    expect_out("dark_first_step", 16, 1);
    cyc(7);
    expect_out("dark_low_beam", 128, 1);
    cyc(5);
    expect_out("dark_low_hold", 128, 1);
    set_in(1, 0, 0, 120);
    cyc(1);
    expect_out("speed_mode_update", 128, 1);
    cyc(1);
    expect_out("speed_first_step", 144, 1);
    cyc(7);
    expect_out("high_beam_sat", 255, 1);
    cyc(3);
    expect_out("high_beam_hold", 255, 1);
    set_in(1, 0, 0, 90);
    cyc(10);
    expect_out("hysteresis_hold", 255, 1);
    set_in(1, 0, 0, 70);
    cyc(2);
    expect_out("ramp_down_first", 239, 1);
    cyc(8);
    expect_out("back_to_low", 128, 1);
    set_in(1, 1, 1, 30);
    cyc(6);
    expect_out("rain_before_step", 128, 1);
    cyc(1);
    expect_out("rain_first_step", 144, 1);
    cyc(10);
    expect_out("rain_beam_low_speed", 192, 1);
    set_in(1, 1, 1, 120);
    cyc(10);
    expect_out("rain_beam_high_speed", 192, 1);
    set_in(1, 1, 0, 120);
    cyc(18);
    expect_out("dry_day_zero", 0, 1);
    cyc(1);
    expect_out("lamp_off_after_zero", 0, 0);
    set_in(1, 0, 0, 120);
    cyc(2);
    set_in(1, 1, 0, 120);
    cyc(15);
    expect_out("glitch_ignored", 0, 0);
    set_in(1, 0, 0, 120);
    cyc(25);
    expect_out("night_high", 255, 1);
    set_in(0, 0, 0, 120);
    cyc(2);
    expect_out("ign_drop_pending", 255, 1);
    cyc(1);
    expect_out("ign_drop_cleared", 0, 0);
    set_in(1, 0, 0, 120);
    cyc(6);
    chk("mid_ramp_nonzero", int'(bus.dim_level != 8'd0), 1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    expect_out("resume_after_reset", 255, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
